baud_tick_gen: RTL and testbench
================================

Name: baud_tick_gen

Overview:
Programmable clock-enable generator for the UART datapath and other low-rate blocks. It divides clk_in by a runtime-loadable divisor. Per period it emits:
- a one-cycle bit tick,
- a one-cycle mid-period tick, used to centre RX sampling,
- a pulse of parametrised width.

Divisor changes are glitch-free: a new divisor takes effect only at a period boundary or on an explicit restart.

Parameters:
SIZE, 16, counter and divisor width in bits.
DIV_RESET, 1250, divisor loaded at reset (12 MHz / 9600 bps).
WIDTH, 1, pulse output high time in clk_in cycles; must be >= 1.

Ports:
clk_in  input  1  system clock; all logic is on its rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  count enable; when low, the counter holds.
restart  input  1  synchronous phase restart (one-cycle strobe).
div_load  input  1  strobe; captures div_in into the pending register.
div_in  input  SIZE  requested divisor D, in clk_in cycles per period.
tick  output  1  one-cycle strobe, once per period.
mid_tick  output  1  one-cycle strobe, half a period after tick.
pulse  output  1  high for WIDTH cycles starting with tick.
count_out  output  SIZE  current counter value.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count = 0; div_active = div_pending = DIV_RESET.
  - tick = mid_tick = pulse = 0.
  - All outputs are registered; none is combinational from inputs.
- Divisor clamp: any divisor below 2, at reset or when loaded, is stored as 2. The minimum period is 2 cycles.
- div_load: div_pending <= clamp(div_in) on the same edge. It does not affect the current period. A later div_load overwrites an earlier one that has not yet been applied.
- Count, when en=1 and restart=0:
  - If count == div_active-1: count <= 0 and div_active <= div_pending (the wrap).
  - Otherwise: count <= count+1.
- Output registers, computed from the current count:
  - tick <= (count == div_active-1). tick is therefore high exactly in the cycle where count_out == 0 after a wrap.
  - mid_tick <= (count == (div_active>>1)-1). mid_tick is high in the cycle where count_out == div_active>>1.
  - pulse <= (next count < WIDTH). pulse rises together with tick and stays high WIDTH cycles.
  - If WIDTH >= div_active, pulse stays high continuously.
- Period: tick repeats every div_active cycles exactly. The mid_tick-to-tick offset is floor(D/2) cycles.
- en=0: count and div_active hold; tick, mid_tick and pulse are 0 on the next edge. When en returns to 1, counting resumes from the held count, with no tick lost or duplicated relative to enabled cycles.
- restart=1 (priority over en and wrap):
  - count <= 0; div_active <= div_pending (or div_in, clamped, if div_load is also high that cycle).
  - tick <= 0; mid_tick <= 0; pulse <= 0.
  - If en=1 after the restart, the first tick comes after the full new period.
- div_load and wrap on the same edge: the newly loaded value goes to div_pending only. It takes effect at the following wrap.
- Reset mid-period: takes effect immediately (asynchronous). The first tick after rst_n deasserts with en=1 comes at edge DIV_RESET.
- Counter overflow: impossible, since count < div_active <= 2^SIZE-1.

Test Plan:
1. Reset release, en=1, defaults: the first tick comes DIV_RESET=1250 edges after release, then every 1250 cycles; mid_tick comes 625 cycles after each tick; pulse is high 1 cycle, coincident with tick.
2. div_in=10 loaded mid-period (count=400): the current period still ends at 1250, then ticks follow every 10 cycles; mid_tick is 5 cycles after each tick; count_out sequence is 0..9.
3. D=10, WIDTH=3 build: pulse is high for count_out 0,1,2 and low for 3..9; with WIDTH=12, pulse is constantly 1.
4. D=10, en dropped for 7 cycles at count=4: count_out holds at 4 and no tick occurs; the next tick arrives 6 enabled cycles after en returns.
5. div_in=0 and div_in=1 loaded, followed by restart: ticks come every 2 cycles; mid_tick coincides with the count_out==1 cycle.
6. D=10, restart at count=7: count_out goes to 0, tick stays low, and the next tick comes 10 cycles later. Then assert rst_n low at count=3: all outputs are 0 immediately and div_active returns to 1250.

Source files
------------

// File: rtl/baud_tick_gen.sv
// Programmable baud-rate clock-enable generator: one-cycle tick, mid-period tick
// and a WIDTH-cycle pulse per period, with divisor changes applied only at a wrap or restart.
module baud_tick_gen #(
    parameter int SIZE      = 16,
    parameter int DIV_RESET = 1250,
    parameter int WIDTH     = 1
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic            en,
    input  logic            restart,
    input  logic            div_load,
    input  logic [SIZE-1:0] div_in,
    output logic            tick,
    output logic            mid_tick,
    output logic            pulse,
    output logic [SIZE-1:0] count_out
);

    // A divisor below 2 cannot produce distinct tick and mid_tick cycles.
    localparam logic [SIZE-1:0] DIV_RST = (DIV_RESET < 2) ? SIZE'(2) : SIZE'(DIV_RESET);
    localparam logic [31:0]     WIDTH_U = 32'(WIDTH);

    function automatic logic [SIZE-1:0] clamp2(input logic [SIZE-1:0] d);
        return (d < SIZE'(2)) ? SIZE'(2) : d;
    endfunction

    logic [SIZE-1:0] count;
    logic [SIZE-1:0] div_active;
    logic [SIZE-1:0] div_pending;
    logic [SIZE-1:0] last_cnt;
    logic [SIZE-1:0] mid_cnt;
    logic [SIZE-1:0] next_cnt;
    logic            at_wrap;

    assign last_cnt  = div_active - SIZE'(1);
    assign mid_cnt   = (div_active >> 1) - SIZE'(1);
    assign at_wrap   = (count == last_cnt);
    assign next_cnt  = at_wrap ? '0 : count + SIZE'(1);
    assign count_out = count;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            div_active  <= DIV_RST;
            div_pending <= DIV_RST;
            tick        <= 1'b0;
            mid_tick    <= 1'b0;
            pulse       <= 1'b0;
        end else begin
            if (div_load)
                div_pending <= clamp2(div_in);

            if (restart) begin
                // A load in the same cycle bypasses the pending register.
                count      <= '0;
                div_active <= div_load ? clamp2(div_in) : div_pending;
                tick       <= 1'b0;
                mid_tick   <= 1'b0;
                pulse      <= 1'b0;
            end else if (en) begin
                count <= next_cnt;
                if (at_wrap)
                    div_active <= div_pending;
                tick     <= at_wrap;
                mid_tick <= (count == mid_cnt);
                pulse    <= (32'(next_cnt) < WIDTH_U);
            end else begin
                tick     <= 1'b0;
                mid_tick <= 1'b0;
                pulse    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: two instances (WIDTH=3 and WIDTH=12) on shared inputs,
// checked every cycle against a period-level reference model.
module tb_baud_tick_gen;

    localparam int SIZE = 16;
    localparam int DIVR = 1250;
    localparam int WA   = 3;
    localparam int WB   = 12;

    logic            clk_in   = 1'b0;
    logic            rst_n    = 1'b0;
    logic            en       = 1'b0;
    logic            restart  = 1'b0;
    logic            div_load = 1'b0;
    logic [SIZE-1:0] div_in   = '0;

    logic            tick_a, mid_a, pulse_a;
    logic            tick_b, mid_b, pulse_b;
    logic [SIZE-1:0] cnt_a, cnt_b;

    always #5 clk_in = ~clk_in;

    baud_tick_gen #(.SIZE(SIZE), .DIV_RESET(DIVR), .WIDTH(WA)) u_a (
        .clk_in(clk_in), .rst_n(rst_n), .en(en), .restart(restart),
        .div_load(div_load), .div_in(div_in),
        .tick(tick_a), .mid_tick(mid_a), .pulse(pulse_a), .count_out(cnt_a)
    );

    baud_tick_gen #(.SIZE(SIZE), .DIV_RESET(DIVR), .WIDTH(WB)) u_b (
        .clk_in(clk_in), .rst_n(rst_n), .en(en), .restart(restart),
        .div_load(div_load), .div_in(div_in),
        .tick(tick_b), .mid_tick(mid_b), .pulse(pulse_b), .count_out(cnt_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: position within the period, active and pending period lengths.
    int m_pos, m_act, m_pend;
    bit e_tick, e_mid, e_pa, e_pb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        m_pos  = 0;
        m_act  = DIVR;
        m_pend = DIVR;
        e_tick = 0; e_mid = 0; e_pa = 0; e_pb = 0;
    endtask

    // One enabled cycle advances the position; outputs describe where the period now stands.
    task automatic model_edge();
        int din, old_len, newpos;
        bit wrapped;
        din     = int'(div_in);
        old_len = m_act;
        e_tick = 0; e_mid = 0; e_pa = 0; e_pb = 0;
        if (restart) begin
            m_pos = 0;
            m_act = div_load ? clampd(din) : m_pend;
        end else if (en) begin
            wrapped = (m_pos + 1 == m_act);
            newpos  = wrapped ? 0 : m_pos + 1;
            if (wrapped) m_act = m_pend;
            m_pos  = newpos;
            e_tick = wrapped;
            e_mid  = (newpos == old_len / 2);
            e_pa   = (newpos < WA);
            e_pb   = (newpos < WB);
        end
        if (div_load) m_pend = clampd(din);
    endtask

    task automatic compare_all();
        check("count_a", 32'(cnt_a), 32'(m_pos));
        check("tick_a",  32'(tick_a), 32'(e_tick));
        check("mid_a",   32'(mid_a),  32'(e_mid));
        check("pulse_a", 32'(pulse_a), 32'(e_pa));
        check("tick_b",  32'(tick_b), 32'(e_tick));
        check("pulse_b", 32'(pulse_b), 32'(e_pb));
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic go_to(input int target, input int budget);
        int k = 0;
        while (m_pos != target && k < budget) begin
            step();
            k++;
        end
        check("reach_cnt", 32'(cnt_a), 32'(target));
    endtask

    task automatic first_tick(input string tag);
        int k = 0;
        do begin
            step();
            k++;
        end while (!tick_a && k < 2000);
        check(tag, 32'(k), 32'(DIVR));
    endtask

    initial begin
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        compare_all();

        // Defaults: 1250-cycle period, mid_tick at 625
        rst_n = 1'b1;
        en    = 1'b1;
        first_tick("first_tick");
        run(DIVR + 10);

        // Load 10 mid-period; current period still ends at 1250
        go_to(400, 1300);
        div_in   = 16'd10;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        go_to(0, 1300);
        run(30);

        // en dropped for 7 cycles at count 4
        go_to(4, 20);
        en = 1'b0;
        run(7);
        check("hold_cnt", 32'(cnt_a), 32'd4);
        en = 1'b1;
        run(20);

        // Divisors 0 and 1 clamp to 2
        div_in   = 16'd0;
        div_load = 1'b1;
        step();
        div_in = 16'd1;
        step();
        div_load = 1'b0;
        restart  = 1'b1;
        step();
        restart = 1'b0;
        run(10);

        // Restart with simultaneous load, then restart at count 7
        div_in   = 16'd10;
        div_load = 1'b1;
        restart  = 1'b1;
        step();
        div_load = 1'b0;
        restart  = 1'b0;
        go_to(7, 20);
        restart = 1'b1;
        step();
        restart = 1'b0;
        run(12);

        // Asynchronous reset mid-period
        go_to(3, 20);
        #2 rst_n = 1'b0;
        #1;
        check("rst_cnt",   32'(cnt_a),   32'd0);
        check("rst_tick",  32'(tick_a),  32'd0);
        check("rst_mid",   32'(mid_a),   32'd0);
        check("rst_pulse", 32'(pulse_b), 32'd0);
        model_reset();
        @(negedge clk_in);
        compare_all();
        rst_n = 1'b1;
        first_tick("tick_after_rst");

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            restart  = ($urandom_range(0, 29) == 0);
            div_load = ($urandom_range(0, 14) == 0);
            div_in   = 16'($urandom_range(0, 12));
            step();
        end
        en = 1'b1; restart = 1'b0; div_load = 1'b0;
        run(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
